tl_ul_mem_arbiter: RTL and testbench

- 2:1 arbiter that shares one TileLink-UL memory slave between the core's instruction-fetch port (m0) and data port (m1).
- Sits between the core's channel_a/channel_d instances and a unified memory adapter.
- Replaces the separate instruction and data memory paths.
- Allows exactly one outstanding transaction and routes each D-channel response back to the master that issued the request.

---
 rtl/tl_ul_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_tl_ul_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tl_ul_mem_arbiter
//
// Shares one TileLink-UL memory slave between the instruction-fetch master
// (m0) and the data master (m1). Only one transaction is in flight at a time.
// The D-channel response is routed back to whichever master issued the
// request.
//
// Optional feature macro: TL_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, m1 (data) wins over m0
//   defined   : a last_grant flop alternates the winner on ties
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   m{0,1}_a_*                 master A channels (valid/ready/opcode/address/
//                              data/size/mask)
//   m{0,1}_d_*                 master D channels (valid/ready/opcode/data)
//   s_a_*                      slave A channel, request fields registered
//   s_d_*                      slave D channel (s_d_size_i is not forwarded)
//   owner_o                    master owning the slave (0=m0, 1=m1)
//   busy_o                     a transaction is in progress
// ---------------------------------------------------------------------------
module tl_ul_mem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int MASK_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   // master 0 (instruction fetch)
   input  logic              m0_a_valid_i,
   output logic              m0_a_ready_o,
   input  logic [2:0]        m0_a_opcode_i,
   input  logic [ADDR_W-1:0] m0_a_address_i,
   input  logic [DATA_W-1:0] m0_a_data_i,
   input  logic [1:0]        m0_a_size_i,
   input  logic [MASK_W-1:0] m0_a_mask_i,
   output logic              m0_d_valid_o,
   input  logic              m0_d_ready_i,
   output logic [2:0]        m0_d_opcode_o,
   output logic [DATA_W-1:0] m0_d_data_o,
   // master 1 (data)
   input  logic              m1_a_valid_i,
   output logic              m1_a_ready_o,
   input  logic [2:0]        m1_a_opcode_i,
   input  logic [ADDR_W-1:0] m1_a_address_i,
   input  logic [DATA_W-1:0] m1_a_data_i,
   input  logic [1:0]        m1_a_size_i,
   input  logic [MASK_W-1:0] m1_a_mask_i,
   output logic              m1_d_valid_o,
   input  logic              m1_d_ready_i,
   output logic [2:0]        m1_d_opcode_o,
   output logic [DATA_W-1:0] m1_d_data_o,
   // slave
   output logic              s_a_valid_o,
   input  logic              s_a_ready_i,
   output logic [2:0]        s_a_opcode_o,
   output logic [ADDR_W-1:0] s_a_address_o,
   output logic [DATA_W-1:0] s_a_data_o,
   output logic [1:0]        s_a_size_o,
   output logic [MASK_W-1:0] s_a_mask_o,
   input  logic              s_d_valid_i,
   output logic              s_d_ready_o,
   input  logic [2:0]        s_d_opcode_i,
   input  logic [1:0]        s_d_size_i,
   input  logic [DATA_W-1:0] s_d_data_i,
   // status
   output logic              owner_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t state_reg, state_next;
   logic   owner_reg;
   logic   winner;
   logic   grant;

   logic [2:0]        s_a_opcode_reg;
   logic [ADDR_W-1:0] s_a_address_reg;
   logic [DATA_W-1:0] s_a_data_reg;
   logic [1:0]        s_a_size_reg;
   logic [MASK_W-1:0] s_a_mask_reg;

   // Both masters gathered into index-able arrays so the datapath below can
   // select by winner/owner instead of duplicating logic per master.
   logic [1:0]        a_valid;
   logic [1:0]        d_ready;
   logic [2:0]        a_opcode  [2];
   logic [ADDR_W-1:0] a_address [2];
   logic [DATA_W-1:0] a_data    [2];
   logic [1:0]        a_size    [2];
   logic [MASK_W-1:0] a_mask    [2];
   logic [1:0]        a_ready;
   logic [1:0]        d_valid;
   logic [2:0]        d_opcode  [2];
   logic [DATA_W-1:0] d_data    [2];
   logic              s_d_ready;
   logic              s_a_valid;

   assign a_valid      = {m1_a_valid_i, m0_a_valid_i};
   assign d_ready      = {m1_d_ready_i, m0_d_ready_i};
   assign a_opcode[0]  = m0_a_opcode_i;
   assign a_opcode[1]  = m1_a_opcode_i;
   assign a_address[0] = m0_a_address_i;
   assign a_address[1] = m1_a_address_i;
   assign a_data[0]    = m0_a_data_i;
   assign a_data[1]    = m1_a_data_i;
   assign a_size[0]    = m0_a_size_i;
   assign a_size[1]    = m1_a_size_i;
   assign a_mask[0]    = m0_a_mask_i;
   assign a_mask[1]    = m1_a_mask_i;

   // The response size carries nothing the masters need.
   logic unused_s_d_size;
   assign unused_s_d_size = ^s_d_size_i;

   // ------------------------------------------------------------------
   // Winner selection
   // ------------------------------------------------------------------
`ifdef TL_ARB_ROUND_ROBIN_EN
   logic last_grant_reg;

   // On a tie the master that was not granted last time wins; a lone
   // requester always wins.
   always_comb begin
      if (a_valid == 2'b11) begin
         winner = ~last_grant_reg;
      end else begin
         winner = a_valid[1];
      end
   end

   // Resets to 1 so that m0 takes the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_reg <= 1'b1;
      end else if (grant) begin
         last_grant_reg <= winner;
      end
   end
`else
   // Fixed priority: the data port beats instruction fetch.
   always_comb begin
      winner = a_valid[1];
   end
`endif

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      grant      = 1'b0;
      a_ready    = 2'b00;
      d_valid    = 2'b00;
      s_d_ready  = 1'b0;
      s_a_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            // Ready is offered only to the winner, so a grant happens
            // exactly when any master is valid.
            if (|a_valid) begin
               grant           = 1'b1;
               a_ready[winner] = 1'b1;
               state_next      = REQ;
            end
         end
         REQ: begin
            s_a_valid = 1'b1;
            if (s_a_ready_i) begin
               state_next = RESP;
            end
         end
         RESP: begin
            d_valid[owner_reg] = s_d_valid_i;
            s_d_ready          = d_ready[owner_reg];
            if (s_d_valid_i && d_ready[owner_reg]) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Request capture and ownership
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_reg       <= 1'b0;
         s_a_opcode_reg  <= '0;
         s_a_address_reg <= '0;
         s_a_data_reg    <= '0;
         s_a_size_reg    <= '0;
         s_a_mask_reg    <= '0;
      end else if (grant) begin
         owner_reg       <= winner;
         s_a_opcode_reg  <= a_opcode[winner];
         s_a_address_reg <= a_address[winner];
         s_a_data_reg    <= a_data[winner];
         s_a_size_reg    <= a_size[winner];
         s_a_mask_reg    <= a_mask[winner];
      end
   end

   // ------------------------------------------------------------------
   // Response fields: only the owner sees the slave's data during RESP.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_resp
         logic sel;
         assign sel          = (state_reg == RESP) && (owner_reg == 1'(gi));
         assign d_opcode[gi] = sel ? s_d_opcode_i : 3'd0;
         assign d_data[gi]   = sel ? s_d_data_i : '0;
      end
   endgenerate

   // A-channel readies come straight from the comb logic, so they are
   // masked while reset is held to keep them low even with valids pending.
   assign m0_a_ready_o  = a_ready[0] & ~reset;
   assign m1_a_ready_o  = a_ready[1] & ~reset;
   assign m0_d_valid_o  = d_valid[0];
   assign m1_d_valid_o  = d_valid[1];
   assign m0_d_opcode_o = d_opcode[0];
   assign m1_d_opcode_o = d_opcode[1];
   assign m0_d_data_o   = d_data[0];
   assign m1_d_data_o   = d_data[1];

   assign s_a_valid_o   = s_a_valid;
   assign s_a_opcode_o  = s_a_opcode_reg;
   assign s_a_address_o = s_a_address_reg;
   assign s_a_data_o    = s_a_data_reg;
   assign s_a_size_o    = s_a_size_reg;
   assign s_a_mask_o    = s_a_mask_reg;
   assign s_d_ready_o   = s_d_ready;

   assign owner_o       = owner_reg;
   assign busy_o        = (state_reg != IDLE);

endmodule

// File: tb/tb_tl_ul_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tl_ul_mem_arbiter
//
// Self-checking bench for tl_ul_mem_arbiter. A table of directed rounds is
// applied first, then randomized rounds whose grant order comes from a
// transaction-level model of the arbitration rules, then the stray-response
// and mid-transaction reset sequences. Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_tl_ul_mem_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int MW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          m0_a_valid_i, m1_a_valid_i;
   logic          m0_a_ready_o, m1_a_ready_o;
   logic [2:0]    m0_a_opcode_i, m1_a_opcode_i;
   logic [AW-1:0] m0_a_address_i, m1_a_address_i;
   logic [DW-1:0] m0_a_data_i, m1_a_data_i;
   logic [1:0]    m0_a_size_i, m1_a_size_i;
   logic [MW-1:0] m0_a_mask_i, m1_a_mask_i;
   logic          m0_d_valid_o, m1_d_valid_o;
   logic          m0_d_ready_i, m1_d_ready_i;
   logic [2:0]    m0_d_opcode_o, m1_d_opcode_o;
   logic [DW-1:0] m0_d_data_o, m1_d_data_o;
   logic          s_a_valid_o, s_a_ready_i;
   logic [2:0]    s_a_opcode_o;
   logic [AW-1:0] s_a_address_o;
   logic [DW-1:0] s_a_data_o;
   logic [1:0]    s_a_size_o;
   logic [MW-1:0] s_a_mask_o;
   logic          s_d_valid_i, s_d_ready_o;
   logic [2:0]    s_d_opcode_i;
   logic [1:0]    s_d_size_i;
   logic [DW-1:0] s_d_data_i;
   logic          owner_o, busy_o;

   always #5 clk = ~clk;

   tl_ul_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
      .clk(clk), .reset(reset),
      .m0_a_valid_i(m0_a_valid_i), .m0_a_ready_o(m0_a_ready_o),
      .m0_a_opcode_i(m0_a_opcode_i), .m0_a_address_i(m0_a_address_i),
      .m0_a_data_i(m0_a_data_i), .m0_a_size_i(m0_a_size_i),
      .m0_a_mask_i(m0_a_mask_i), .m0_d_valid_o(m0_d_valid_o),
      .m0_d_ready_i(m0_d_ready_i), .m0_d_opcode_o(m0_d_opcode_o),
      .m0_d_data_o(m0_d_data_o),
      .m1_a_valid_i(m1_a_valid_i), .m1_a_ready_o(m1_a_ready_o),
      .m1_a_opcode_i(m1_a_opcode_i), .m1_a_address_i(m1_a_address_i),
      .m1_a_data_i(m1_a_data_i), .m1_a_size_i(m1_a_size_i),
      .m1_a_mask_i(m1_a_mask_i), .m1_d_valid_o(m1_d_valid_o),
      .m1_d_ready_i(m1_d_ready_i), .m1_d_opcode_o(m1_d_opcode_o),
      .m1_d_data_o(m1_d_data_o),
      .s_a_valid_o(s_a_valid_o), .s_a_ready_i(s_a_ready_i),
      .s_a_opcode_o(s_a_opcode_o), .s_a_address_o(s_a_address_o),
      .s_a_data_o(s_a_data_o), .s_a_size_o(s_a_size_o),
      .s_a_mask_o(s_a_mask_o),
      .s_d_valid_i(s_d_valid_i), .s_d_ready_o(s_d_ready_o),
      .s_d_opcode_i(s_d_opcode_i), .s_d_size_i(s_d_size_i),
      .s_d_data_i(s_d_data_i),
      .owner_o(owner_o), .busy_o(busy_o)
   );

   int tests  = 0;
   int failed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- request model ----------------
   typedef struct {
      logic [2:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [1:0]    size;
      logic [MW-1:0] mask;
   } req_t;

   req_t req [2];
   bit   pend [2];
   bit   model_last = 1'b1;   // master most recently granted (round-robin model)

   // Arbitration rule: fixed m1-over-m0, or alternate on ties.
   function automatic int pick();
      if (pend[0] && pend[1]) begin
`ifdef TL_ARB_ROUND_ROBIN_EN
         return model_last ? 0 : 1;
`else
         return 1;
`endif
      end
      return pend[1] ? 1 : 0;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      int k = $urandom_range(0, 2);
      r.op   = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : 3'd4;
      r.addr = AW'($urandom);
      r.data = $urandom;
      r.size = 2'($urandom);
      r.mask = MW'($urandom);
      return r;
   endfunction

   function automatic logic a_ready_of(input int m);
      return (m != 0) ? m1_a_ready_o : m0_a_ready_o;
   endfunction
   function automatic logic d_valid_of(input int m);
      return (m != 0) ? m1_d_valid_o : m0_d_valid_o;
   endfunction
   function automatic logic [DW-1:0] d_data_of(input int m);
      return (m != 0) ? m1_d_data_o : m0_d_data_o;
   endfunction
   function automatic logic [2:0] d_opcode_of(input int m);
      return (m != 0) ? m1_d_opcode_o : m0_d_opcode_o;
   endfunction

   task automatic drive_masters();
      m0_a_valid_i = pend[0];   m1_a_valid_i = pend[1];
      m0_a_opcode_i = req[0].op;   m1_a_opcode_i = req[1].op;
      m0_a_address_i = req[0].addr; m1_a_address_i = req[1].addr;
      m0_a_data_i = req[0].data;   m1_a_data_i = req[1].data;
      m0_a_size_i = req[0].size;   m1_a_size_i = req[1].size;
      m0_a_mask_i = req[0].mask;   m1_a_mask_i = req[1].mask;
   endtask

   // One full transaction for master w: grant, REQ with aw slave-wait cycles,
   // RESP with dw slave-wait cycles and rw master-wait cycles.
   task automatic serve_one(input int w, input int aw, input int dw, input int rw,
                            input logic [DW-1:0] rdata);
      logic [2:0] rop;
      int cyc;
      bit done;
      bit mrdy;
      // grant cycle
      @(negedge clk);
      drive_masters();
      s_a_ready_i = 1'b0; s_d_valid_i = 1'b0;
      m0_d_ready_i = 1'b0; m1_d_ready_i = 1'b0;
      #1;
      chk($sformatf("grant_m%0d", w), 64'(a_ready_of(w)), 64'd1);
      chk("loser_ready", 64'(a_ready_of(1 - w)), 64'd0);
      chk("busy_idle", 64'(busy_o), 64'd0);
      chk("s_a_valid_idle", 64'(s_a_valid_o), 64'd0);
      model_last = (w != 0);
      pend[w] = 1'b0;
      // request phase
      for (int i = 0; i <= aw; i++) begin
         @(negedge clk);
         drive_masters();
         s_a_ready_i = (i == aw);
         #1;
         chk("s_a_valid", 64'(s_a_valid_o), 64'd1);
         chk("s_a_opcode", 64'(s_a_opcode_o), 64'(req[w].op));
         chk("s_a_address", 64'(s_a_address_o), 64'(req[w].addr));
         chk("s_a_data", 64'(s_a_data_o), 64'(req[w].data));
         chk("s_a_size", 64'(s_a_size_o), 64'(req[w].size));
         chk("s_a_mask", 64'(s_a_mask_o), 64'(req[w].mask));
         chk("owner", 64'(owner_o), 64'(w));
         chk("busy_req", 64'(busy_o), 64'd1);
         chk("a_ready_req", 64'({m1_a_ready_o, m0_a_ready_o}), 64'd0);
         chk("d_valid_req", 64'({m1_d_valid_o, m0_d_valid_o}), 64'd0);
      end
      // response phase
      rop  = (req[w].op == 3'd4) ? 3'd1 : 3'd0;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 50) begin
         @(negedge clk);
         drive_masters();
         s_a_ready_i  = 1'b0;
         s_d_valid_i  = (cyc >= dw);
         s_d_opcode_i = rop;
         s_d_data_i   = rdata;
         s_d_size_i   = req[w].size;
         mrdy = (cyc >= dw + rw);
         if (w != 0) begin
            m1_d_ready_i = mrdy; m0_d_ready_i = 1'($urandom);
         end else begin
            m0_d_ready_i = mrdy; m1_d_ready_i = 1'($urandom);
         end
         #1;
         chk("owner_d_valid", 64'(d_valid_of(w)), 64'(s_d_valid_i));
         chk("other_d_valid", 64'(d_valid_of(1 - w)), 64'd0);
         chk("s_d_ready", 64'(s_d_ready_o), 64'(mrdy));
         if (s_d_valid_i) begin
            chk("d_data", 64'(d_data_of(w)), 64'(rdata));
            chk("d_opcode", 64'(d_opcode_of(w)), 64'(rop));
         end
         done = s_d_valid_i && mrdy;
         cyc++;
      end
      if (!done) chk("resp_timeout", 64'd0, 64'd1);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit            r0, r1;
      logic [2:0]    op0;
      logic [AW-1:0] a0;
      logic [2:0]    op1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic [DW-1:0] rdata;
      int            aw, dw, rw;
      int            first;
   } vec_t;

`ifdef TL_ARB_ROUND_ROBIN_EN
   localparam int TIE_A = 0;   // ties after an m1 grant (entries 2,3)
   localparam int TIE_B = 1;   // tie after an m0 grant (entry 5)
`else
   localparam int TIE_A = 1;
   localparam int TIE_B = 1;
`endif

   vec_t tbl [6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1, 0, 3'd4, 12'h010, 3'd0, 12'h000, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0};
      tbl[1] = '{0, 1, 3'd4, 12'h000, 3'd0, 12'h020, 32'hA5A50001, 32'h0, 1, 0, 0, 1};
      tbl[2] = '{1, 1, 3'd4, 12'h004, 3'd0, 12'h100, 32'h12345678, 32'hCAFE0002, 0, 0, 0, TIE_A};
      tbl[3] = '{1, 1, 3'd4, 12'h0F0, 3'd4, 12'h0F4, 32'h0, 32'h0BAD0003, 3, 1, 2, TIE_A};
      tbl[4] = '{1, 0, 3'd1, 12'h200, 3'd0, 12'h000, 32'h0, 32'h0, 0, 2, 1, 0};
      tbl[5] = '{1, 1, 3'd0, 12'h300, 3'd1, 12'h304, 32'h55AA55AA, 32'h77, 1, 0, 1, TIE_B};

      pend[0] = 1'b1; pend[1] = 1'b0;
      req[0] = '{3'd4, 12'h010, 32'h0, 2'd2, 2'd3};
      req[1] = '{3'd0, 12'h000, 32'h0, 2'd2, 2'd3};
      drive_masters();
      s_a_ready_i = 1'b0; s_d_valid_i = 1'b0; s_d_opcode_i = '0;
      s_d_size_i = '0; s_d_data_i = '0;
      m0_d_ready_i = 1'b0; m1_d_ready_i = 1'b0;

      // reset state, with a request already pending
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_a_ready", 64'({m1_a_ready_o, m0_a_ready_o}), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_owner", 64'(owner_o), 64'd0);
      chk("rst_s_a_valid", 64'(s_a_valid_o), 64'd0);
      chk("rst_s_a_addr", 64'(s_a_address_o), 64'd0);
      chk("rst_s_d_ready", 64'(s_d_ready_o), 64'd0);
      pend[0] = 1'b0;
      drive_masters();
      @(negedge clk);
      reset = 1'b0;

      // directed table
      for (int t = 0; t < 6; t++) begin
         pend[0] = tbl[t].r0;
         pend[1] = tbl[t].r1;
         req[0] = '{tbl[t].op0, tbl[t].a0, 32'h0, 2'd2, 2'd3};
         req[1] = '{tbl[t].op1, tbl[t].a1, tbl[t].d1, 2'd2, 2'd3};
         serve_one(tbl[t].first, tbl[t].aw, tbl[t].dw, tbl[t].rw, tbl[t].rdata);
         if (tbl[t].r0 && tbl[t].r1)
            serve_one(1 - tbl[t].first, tbl[t].aw, tbl[t].dw, tbl[t].rw, tbl[t].rdata ^ 32'hFFFF);
         $display("[TB] table entry %0d done", t);
      end

      // randomized rounds checked against the arbitration model
      for (int r = 0; r < 40; r++) begin
         int sel = $urandom_range(1, 3);
         pend[0] = sel[0];
         pend[1] = sel[1];
         req[0] = rand_req();
         req[1] = rand_req();
         while (pend[0] || pend[1]) begin
            serve_one(pick(), $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom);
         end
         $display("[TB] random round %0d done", r);
      end

      // stray slave response while idle
      @(negedge clk);
      pend[0] = 1'b0; pend[1] = 1'b0;
      drive_masters();
      s_d_valid_i = 1'b1; s_d_data_i = 32'h5757; s_d_opcode_i = 3'd1;
      m0_d_ready_i = 1'b1; m1_d_ready_i = 1'b1;
      repeat (2) begin
         #1;
         chk("stray_s_d_ready", 64'(s_d_ready_o), 64'd0);
         chk("stray_d_valid", 64'({m1_d_valid_o, m0_d_valid_o}), 64'd0);
         chk("stray_busy", 64'(busy_o), 64'd0);
         @(negedge clk);
      end
      s_d_valid_i = 1'b0; m0_d_ready_i = 1'b0; m1_d_ready_i = 1'b0;
      $display("[TB] stray response sequence done");

      // reset during RESP
      pend[0] = 1'b1;
      req[0] = '{3'd4, 12'h040, 32'h0, 2'd2, 2'd3};
      drive_masters();
      #1;
      chk("mid_grant", 64'(m0_a_ready_o), 64'd1);
      pend[0] = 1'b0;
      @(negedge clk);
      drive_masters();
      s_a_ready_i = 1'b1;
      #1;
      chk("mid_s_a_valid", 64'(s_a_valid_o), 64'd1);
      @(negedge clk);
      s_a_ready_i = 1'b0; s_d_valid_i = 1'b0; m0_d_ready_i = 1'b1;
      #1;
      chk("mid_resp_busy", 64'(busy_o), 64'd1);
      chk("mid_resp_s_d_ready", 64'(s_d_ready_o), 64'd1);
      reset = 1'b1;
      #1;
      chk("async_s_a_valid", 64'(s_a_valid_o), 64'd0);
      chk("async_s_d_ready", 64'(s_d_ready_o), 64'd0);
      chk("async_busy", 64'(busy_o), 64'd0);
      chk("async_owner", 64'(owner_o), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      m0_d_ready_i = 1'b0;
      model_last = 1'b1;
      pend[0] = 1'b1;
      req[0] = '{3'd4, 12'h044, 32'h0, 2'd2, 2'd3};
      serve_one(0, 0, 0, 0, 32'h600D0044);
      $display("[TB] reset mid-operation sequence done");

      @(negedge clk);
      s_d_valid_i = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
